// File: rtl/dma_pkg.sv
// Shared types and constants for the OAM DMA bus arbiter.
// The echo-mirror option is controlled by DMA_ECHO_MIRROR_EN in the top.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2
  } dma_state_e;

  localparam int          OAM_LEN      = 160;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] IO_BASE      = 16'hFF00;
  localparam logic [7:0]  ECHO_BASE    = 8'hE0;

endpackage

// File: rtl/dma_addr_decode.sv
// CPU address region decode and memory / I/O bus routing.
// The DMA engine overrides the memory bus while xfer is high.
module dma_addr_decode
  import dma_pkg::*;
(
  input  logic        rst_n,
  input  logic        xfer,
  input  logic        cpu_phi,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  input  logic [15:0] dma_a,
  input  logic [7:0]  src_reg,
  output logic        reg_wr,
  output logic [15:0] mem_a,
  output logic [7:0]  mem_dout,
  input  logic [7:0]  mem_din,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  io_a,
  output logic [7:0]  io_dout,
  input  logic [7:0]  io_din,
  output logic        io_rd,
  output logic        io_wr
);

  logic is_reg;
  logic is_io;
  logic is_mem;

  // Region decode, bus muxing and CPU read-data select.
  always_comb begin
    is_reg   = (cpu_a == DMA_REG_ADDR);
    is_io    = (cpu_a >= IO_BASE) && !is_reg;
    is_mem   = (cpu_a < IO_BASE);
    reg_wr   = cpu_wr & is_reg;
    io_a     = cpu_a[7:0];
    io_dout  = cpu_dout;
    io_rd    = rst_n & cpu_rd & is_io;
    io_wr    = rst_n & cpu_wr & is_io;
    mem_a    = cpu_a;
    mem_dout = cpu_dout;
    mem_rd   = rst_n & cpu_rd & is_mem;
    mem_wr   = rst_n & cpu_wr & is_mem;
    if (xfer) begin
      mem_a    = dma_a;
      mem_dout = 8'h00;
      mem_rd   = rst_n & cpu_phi;
      mem_wr   = 1'b0;
    end
    cpu_din = mem_din;
    unique case (1'b1)
      is_reg:  cpu_din = src_reg;
      is_io:   cpu_din = io_din;
      default: cpu_din = xfer ? 8'hFF : mem_din;
    endcase
  end

endmodule

// File: rtl/dma_bus_arbiter.sv
// OAM DMA engine at FF46 plus CPU bus arbitration.
// DMA_ECHO_MIRROR_EN folds source pages E0-FF down to C0-DF on mem_a.
module dma_bus_arbiter
  import dma_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_phi,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [15:0] mem_a,
  output logic [7:0]  mem_dout,
  input  logic [7:0]  mem_din,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  io_a,
  output logic [7:0]  io_dout,
  input  logic [7:0]  io_din,
  output logic        io_rd,
  output logic        io_wr,
  output logic [7:0]  oam_a,
  output logic [7:0]  oam_wdata,
  output logic        oam_we,
  output logic        dma_active
);

  localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 1);

  dma_state_e state_q, state_d;
  logic       phi_q;
  logic [7:0] src_q, src_d;
  logic [7:0] idx_q, idx_d;
  logic       oam_we_q, oam_we_d;
  logic [7:0] oam_a_q, oam_a_d;
  logic [7:0] oam_wdata_q, oam_wdata_d;
  logic       active_q, active_d;
  logic       m_start;
  logic       m_sample;
  logic       reg_wr;
  logic [7:0] src_hi;

  assign m_start    = cpu_phi & ~phi_q;
  assign m_sample   = cpu_phi & phi_q;
  assign oam_we     = oam_we_q;
  assign oam_a      = oam_a_q;
  assign oam_wdata  = oam_wdata_q;
  assign dma_active = active_q;

  // Source page as presented on the memory bus.
  always_comb begin
`ifdef DMA_ECHO_MIRROR_EN
    src_hi = (src_q >= ECHO_BASE) ? src_q - 8'h20 : src_q;
`else
    src_hi = src_q;
`endif
  end

  dma_addr_decode u_dec (
    .rst_n    (rst_n),
    .xfer     (state_q == XFER),
    .cpu_phi  (cpu_phi),
    .cpu_a    (cpu_a),
    .cpu_dout (cpu_dout),
    .cpu_rd   (cpu_rd),
    .cpu_wr   (cpu_wr),
    .cpu_din  (cpu_din),
    .dma_a    ({src_hi, idx_q}),
    .src_reg  (src_q),
    .reg_wr   (reg_wr),
    .mem_a    (mem_a),
    .mem_dout (mem_dout),
    .mem_din  (mem_din),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .io_a     (io_a),
    .io_dout  (io_dout),
    .io_din   (io_din),
    .io_rd    (io_rd),
    .io_wr    (io_wr)
  );

  // Engine next state; a register write always restarts.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    idx_d       = idx_q;
    oam_we_d    = 1'b0;
    oam_a_d     = oam_a_q;
    oam_wdata_d = oam_wdata_q;
    active_d    = active_q;
    unique case (state_q)
      START: begin
        if (m_start) begin
          state_d  = XFER;
          active_d = 1'b1;
          idx_d    = 8'd0;
        end
      end
      XFER: begin
        if (m_sample) begin
          oam_we_d    = 1'b1;
          oam_a_d     = idx_q;
          oam_wdata_d = mem_din;
          if (idx_q == LAST_IDX) begin
            state_d  = IDLE;
            active_d = 1'b0;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      default: ;
    endcase
    if (reg_wr) begin
      src_d    = cpu_dout;
      state_d  = START;
      idx_d    = 8'd0;
      active_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phi_q       <= 1'b0;
      src_q       <= 8'h00;
      idx_q       <= 8'd0;
      oam_we_q    <= 1'b0;
      oam_a_q     <= 8'h00;
      oam_wdata_q <= 8'h00;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      phi_q       <= cpu_phi;
      src_q       <= src_d;
      idx_q       <= idx_d;
      oam_we_q    <= oam_we_d;
      oam_a_q     <= oam_a_d;
      oam_wdata_q <= oam_wdata_d;
      active_q    <= active_d;
    end
  end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed self-checking bench for dma_bus_arbiter.
// Build with DMA_ECHO_MIRROR_EN to exercise the echo mirror.
module tb_dma_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_phi;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [15:0] mem_a;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  io_a;
  logic [7:0]  io_dout;
  logic [7:0]  io_din;
  logic        io_rd;
  logic        io_wr;
  logic [7:0]  oam_a;
  logic [7:0]  oam_wdata;
  logic        oam_we;
  logic        dma_active;

  logic [1:0]  ph = 2'd0;
  logic        mem_ov_en;
  logic [7:0]  mem_ov;
  int          total = 0;
  int          bad = 0;
  int          exp_k = 0;
  int          pulses = 0;
  int          act_m = 0;
  int          saved;

  dma_bus_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_phi    (cpu_phi),
    .cpu_a      (cpu_a),
    .cpu_dout   (cpu_dout),
    .cpu_din    (cpu_din),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .mem_a      (mem_a),
    .mem_dout   (mem_dout),
    .mem_din    (mem_din),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .io_a       (io_a),
    .io_dout    (io_dout),
    .io_din     (io_din),
    .io_rd      (io_rd),
    .io_wr      (io_wr),
    .oam_a      (oam_a),
    .oam_wdata  (oam_wdata),
    .oam_we     (oam_we),
    .dma_active (dma_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ph <= ph + 2'd1;
  assign cpu_phi = (ph < 2'd2);
  assign mem_din = mem_ov_en ? mem_ov : mem_a[7:0];
  assign io_din  = ~io_a;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  always @(negedge clk) begin
    if (oam_we) begin
      chk("oam_a", 32'(oam_a), 32'(exp_k));
      chk("oam_wdata", 32'(oam_wdata), 32'(exp_k));
      exp_k++;
      pulses++;
    end
    if (ph == 2'd1 && dma_active) act_m++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic to_ph0();
    do step(); while (ph != 2'd0);
  endtask

  task automatic reg_write(input logic [7:0] v);
    to_ph0();
    cpu_a    = 16'hFF46;
    cpu_dout = v;
    cpu_wr   = 1'b1;
    repeat (4) step();
    cpu_wr   = 1'b0;
  endtask

  task automatic wait_k(input int target);
    for (int i = 0; i < 2000; i++) begin
      if (exp_k >= target) break;
      step();
    end
    chk("wait_k", 32'(exp_k), 32'(target));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 800; i++) begin
      if (!dma_active) break;
      step();
    end
    chk("wait_done", 32'(dma_active), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    cpu_a     = 16'h0000;
    cpu_dout  = 8'h00;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    mem_ov_en = 1'b0;
    mem_ov    = 8'h00;
    step();
    step();
    chk("rst_we", 32'(oam_we), 32'd0);
    chk("rst_act", 32'(dma_active), 32'd0);
    chk("rst_oam_a", 32'(oam_a), 32'd0);
    chk("rst_memrd", 32'(mem_rd), 32'd0);
    rst_n = 1'b1;
    step();

    cpu_a = 16'hFF46; cpu_rd = 1'b1; #1;
    chk("rb_reset", 32'(cpu_din), 32'h00);
    chk("rb_no_io", 32'(io_rd), 32'd0);

    mem_ov_en = 1'b1; mem_ov = 8'h5A;
    cpu_a = 16'h1234; #1;
    chk("idle_mem_a", 32'(mem_a), 32'h1234);
    chk("idle_mem_rd", 32'(mem_rd), 32'd1);
    chk("idle_din", 32'(cpu_din), 32'h5A);
    cpu_rd = 1'b0; mem_ov_en = 1'b0;
    cpu_a = 16'hFF80; cpu_dout = 8'h11; cpu_wr = 1'b1; #1;
    chk("io_a", 32'(io_a), 32'h80);
    chk("io_wr", 32'(io_wr), 32'd1);
    chk("io_dout", 32'(io_dout), 32'h11);
    chk("io_memwr", 32'(mem_wr), 32'd0);
    cpu_wr = 1'b0;

    exp_k = 0; pulses = 0; act_m = 0;
    reg_write(8'hC1);
    chk("start_wait", 32'(dma_active), 32'd0);
    step();
    chk("xfer_act", 32'(dma_active), 32'd1);
    chk("xfer_a0", 32'(mem_a), 32'hC100);
    chk("xfer_rd", 32'(mem_rd), 32'd1);
    chk("no_pulse", 32'(pulses), 32'd0);
    step();
    chk("first_pulse", 32'(pulses), 32'd1);
    wait_k(20);
    to_ph0();
    cpu_a = 16'hC000; cpu_rd = 1'b1; #1;
    chk("blk_din", 32'(cpu_din), 32'hFF);
    chk("blk_mem_a", 32'(mem_a), 32'({8'hC1, 8'(exp_k)}));
    cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_dout = 8'h77; #1;
    chk("blk_wr", 32'(mem_wr), 32'd0);
    cpu_wr = 1'b0; cpu_a = 16'hFF85; cpu_rd = 1'b1; #1;
    chk("dma_io_rd", 32'(io_rd), 32'd1);
    chk("dma_io_din", 32'(cpu_din), 32'h7A);
    cpu_rd = 1'b0;
    wait_done();
    chk("full_pulses", 32'(pulses), 32'd160);
    chk("full_mcyc", 32'(act_m), 32'd160);

    exp_k = 0; pulses = 0;
    reg_write(8'hC1);
    wait_k(51);
    exp_k = 0;
    reg_write(8'h80);
    chk("rs_hold", 32'(pulses), 32'd51);
    step();
    chk("rs_a", 32'(mem_a), 32'h8000);
    step();
    chk("rs_first", 32'(pulses), 32'd52);
    wait_done();
    chk("rs_total", 32'(pulses), 32'd211);

    exp_k = 0;
    reg_write(8'hC1);
    wait_k(90);
    rst_n = 1'b0; #1;
    chk("mr_we", 32'(oam_we), 32'd0);
    chk("mr_act", 32'(dma_active), 32'd0);
    chk("mr_memrd", 32'(mem_rd), 32'd0);
    saved = pulses;
    repeat (3) step();
    rst_n = 1'b1;
    cpu_a = 16'hFF46; cpu_rd = 1'b1; #1;
    chk("mr_rb", 32'(cpu_din), 32'h00);
    cpu_rd = 1'b0;
    repeat (200) step();
    chk("mr_quiet", 32'(pulses), 32'(saved));
    chk("mr_idle", 32'(dma_active), 32'd0);

    exp_k = 0;
    reg_write(8'hE3);
    step();
`ifdef DMA_ECHO_MIRROR_EN
    chk("echo_a", 32'(mem_a), 32'hC300);
`else
    chk("echo_a", 32'(mem_a), 32'hE300);
`endif
    cpu_a = 16'hFF46; cpu_rd = 1'b1; #1;
    chk("echo_rb", 32'(cpu_din), 32'hE3);
    cpu_rd = 1'b0;
    wait_done();
    chk("echo_cnt", 32'(exp_k), 32'd160);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
- Sits between the CPU bus master (a/dout/din/rd/wr/phi) and the system memory bus. Implements the OAM DMA engine at FF46.
- Decodes CPU accesses into two ports: the memory bus for 0000-FEFF and the I/O-HRAM bus for FF00-FFFF.
- While DMA is active, the engine owns the memory bus for 160 M-cycles and copies {src,00}..{src,9F} into OAM through a dedicated write port.
- CPU accesses to FF00-FFFF continue to run during DMA.

Parameters:
OAM_LEN, 160, number of bytes per DMA transfer
DMA_REG_ADDR, 16'hFF46, CPU address of the DMA source/trigger register

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cpu_phi  in  1  CPU M-cycle phase; high 2 clocks per 4-clock M-cycle
cpu_a  in  16  CPU address
cpu_dout  in  8  CPU write data
cpu_din  out  8  read data returned to CPU (combinational)
cpu_rd  in  1  CPU read strobe
cpu_wr  in  1  CPU write strobe
mem_a  out  16  memory bus address
mem_dout  out  8  memory bus write data
mem_din  in  8  memory bus read data
mem_rd  out  1  memory bus read
mem_wr  out  1  memory bus write
io_a  out  8  I/O-HRAM offset (cpu_a[7:0])
io_dout  out  8  I/O write data
io_din  in  8  I/O read data
io_rd  out  1  I/O read
io_wr  out  1  I/O write
oam_a  out  8  OAM write index
oam_wdata  out  8  OAM write data
oam_we  out  1  OAM write enable, one clock
dma_active  out  1  high while the engine owns the memory bus

Behaviour:
- Reset (async, rst_n low):
  - State IDLE; src_reg=8'h00; idx=0.
  - Registered outputs: oam_we=0, oam_a=0, oam_wdata=0, dma_active=0.
  - mem_rd, mem_wr, io_rd and io_wr evaluate low.
  - Reset mid-transfer aborts immediately. No further OAM writes occur.
- Strobes (phi_q is cpu_phi registered):
  - m_start = cpu_phi & ~phi_q.
  - m_sample = cpu_phi & phi_q, i.e. the second high clock, where CPU and DMA latch read data.
- Register write: cpu_wr & cpu_a==DMA_REG_ADDR sets src_reg<=cpu_dout on that clock and forces state START. A write during XFER restarts the transfer with idx=0.
- Register read: cpu_rd & cpu_a==DMA_REG_ADDR gives cpu_din=src_reg. No I/O strobe is issued.
- CPU routing (combinational):
  - cpu_a>=FF00, excluding DMA_REG_ADDR: goes to the io_* port in every state.
  - cpu_a<FF00 in IDLE/START: passes to mem_* (mem_a=cpu_a, mem_dout=cpu_dout, strobes mirrored).
  - cpu_a<FF00 in XFER: blocked. Writes are dropped and cpu_din=8'hFF.
- States:
  - IDLE: waits for a register write, which moves to START.
  - START: on the next m_start, moves to XFER and sets dma_active=1. This gives a one-M-cycle startup delay.
  - XFER, memory bus: mem_a={src,idx} and mem_rd=cpu_phi; mem_wr=0.
  - XFER, on m_sample: oam_a<=idx, oam_wdata<=mem_din, oam_we<=1 for one clock, then idx<=idx+1.
  - XFER, end condition: on the m_sample where idx==OAM_LEN-1, state becomes IDLE and dma_active<=0 on the same edge.
- Transfer length and width:
  - Exactly one byte per M-cycle; 160 OAM writes per transfer.
  - idx is 8 bits and never exceeds 159; there is no wrap.
- Simultaneous events:
  - Register write on the same clock as the final m_sample: restart wins, giving state START and idx=0.
  - oam_we from the final byte still pulses.

Optional Feature:
- DMA_ECHO_MIRROR_EN defined: source high byte E0-FF is mapped to src-8'h20 (echo RAM mirror to C0-DF) on mem_a only. Register readback returns the unmodified src_reg.
- Undefined: mem_a uses src_reg unmodified.

Decomposition:
- Shared package dma_pkg holds:
  - state enum (IDLE, START, XFER);
  - constants OAM_LEN, DMA_REG_ADDR, IO_BASE=16'hFF00, ECHO_BASE=8'hE0.
- One natural sub-module, dma_addr_decode: combinational CPU address region decode and bus-routing mux. The engine FSM stays in the top.

Test Plan:
- Idle passthrough: CPU reads 0x1234, mem_din=8'h5A -> mem_a=16'h1234, mem_rd=1, cpu_din=8'h5A. CPU writes FF80=8'h11 -> io_a=8'h80, io_wr=1, mem_wr=0.
- Full transfer: CPU writes FF46=8'hC1, memory returns low address byte -> exactly 160 oam_we pulses.
  - Each write has oam_a=k and oam_wdata=k for k=0..159.
  - First pulse occurs in the second M-cycle after the write.
  - dma_active is high for 160 M-cycles.
- Blocking during DMA: CPU reads 0xC000 mid-transfer -> cpu_din=8'hFF and mem_a still {C1,idx}. CPU reads FF85 -> io_rd=1 and cpu_din=io_din.
- Restart: second write FF46=8'h80 at idx=50 -> next OAM pulse after one-M-cycle delay has oam_a=0 and source address 16'h8000. Total pulses = 51+160.
- Reset mid-transfer: rst_n low at idx=90 -> oam_we=0, dma_active=0 and src read back as 8'h00. No OAM pulses after release.
- Echo (with DMA_ECHO_MIRROR_EN): write FF46=8'hE3 -> mem_a=16'hC300..C39F, and readback FF46=8'hE3. Without the macro, mem_a=16'hE300.
